// File: rtl/pipeline_merge.sv
// Two-to-one valid/ready merge into a registered 2-entry output buffer.
// Define PIPELINE_MERGE_FAIR_EN for round-robin instead of main priority.
module pipeline_merge #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          clear_i,
  input  logic [DW-1:0] data_in_main_i,
  input  logic          data_in_main_valid_i,
  output logic          data_in_main_ready_o,
  input  logic [DW-1:0] data_in_secondary_i,
  input  logic          data_in_secondary_valid_i,
  output logic          data_in_secondary_ready_o,
  output logic [DW-1:0] data_out_o,
  output logic          data_out_valid_o,
  input  logic          data_out_ready_i,
  output logic          data_out_src_o
);

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } entry_t;

  entry_t     mem [2];
  logic       head;
  logic       tail;
  logic [1:0] count;

  logic   space;
  logic   push_m;
  logic   push_s;
  logic   push;
  logic   pop;
  entry_t push_e;

  // Ready comes from the registered count only, never from the output side.
  assign space = (count < 2'd2);

`ifdef PIPELINE_MERGE_FAIR_EN
  logic pref;
  logic both;

  assign both = data_in_main_valid_i & data_in_secondary_valid_i;

  always_comb begin
    data_in_main_ready_o      = space;
    data_in_secondary_ready_o = space;
    if (both) begin
      data_in_main_ready_o      = space & ~pref;
      data_in_secondary_ready_o = space & pref;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pref <= 1'b0;
    end else if (clear_i) begin
      pref <= 1'b0;
    end else if (push_m) begin
      pref <= 1'b1;
    end else if (push_s) begin
      pref <= 1'b0;
    end
  end
`else
  assign data_in_main_ready_o      = space;
  assign data_in_secondary_ready_o = space & ~data_in_main_valid_i;
`endif

  assign push_m = data_in_main_valid_i & data_in_main_ready_o;
  assign push_s = data_in_secondary_valid_i
                & data_in_secondary_ready_o;
  assign push   = push_m | push_s;

  always_comb begin
    push_e.src  = 1'b0;
    push_e.data = data_in_main_i;
    if (push_s) begin
      push_e.src  = 1'b1;
      push_e.data = data_in_secondary_i;
    end
  end

  assign data_out_valid_o = (count != 2'd0);
  assign data_out_o       = mem[head].data;
  assign data_out_src_o   = mem[head].src;
  assign pop              = data_out_valid_o & data_out_ready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (clear_i) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= push_e;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_merge.sv
// Randomized and directed bench for pipeline_merge against a queue model.
// Builds for both arbitration variants (PIPELINE_MERGE_FAIR_EN).
module tb_pipeline_merge;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] dm = '0;
  logic       mv = 1'b0;
  logic       rm;
  logic [7:0] ds = '0;
  logic       sv = 1'b0;
  logic       rs;
  logic [7:0] dout;
  logic       ov;
  logic       ordy = 1'b0;
  logic       osrc;

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  logic [8:0] olog[$];
  bit         pref = 1'b0;
  bit         hm;
  bit         hs;

  always #5 clk = ~clk;

  pipeline_merge #(.DW(8)) dut (
    .clk_i                     (clk),
    .arst_i                    (arst),
    .clear_i                   (clr),
    .data_in_main_i            (dm),
    .data_in_main_valid_i      (mv),
    .data_in_main_ready_o      (rm),
    .data_in_secondary_i       (ds),
    .data_in_secondary_valid_i (sv),
    .data_in_secondary_ready_o (rs),
    .data_out_o                (dout),
    .data_out_valid_o          (ov),
    .data_out_ready_i          (ordy),
    .data_out_src_o            (osrc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare against the model, then advance the model.
  task automatic cyc();
    bit sp, erm, ers, pop;
    @(negedge clk);
    sp = (q.size() < 2);
`ifdef PIPELINE_MERGE_FAIR_EN
    if (mv && sv) begin
      erm = sp && !pref;
      ers = sp && pref;
    end else begin
      erm = sp;
      ers = sp;
    end
`else
    erm = sp;
    ers = sp && !mv;
    check("sec_while_main", mv && sv && rs, 0);
`endif
    check("rdy_m", rm, erm);
    check("rdy_s", rs, ers);
    check("ovalid", ov, q.size() != 0);
    if (q.size() != 0) check("head", {osrc, dout}, q[0]);
    hm  = mv && erm;
    hs  = sv && ers;
    pop = (q.size() != 0) && ordy;
    if (ov && ordy) olog.push_back({osrc, dout});
    @(posedge clk);
    if (clr) begin
      q.delete();
      pref = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (hm) begin
        q.push_back({1'b0, dm});
        pref = 1'b1;
      end else if (hs) begin
        q.push_back({1'b1, ds});
        pref = 1'b0;
      end
    end
    #1;
  endtask

  task automatic push_m(input logic [7:0] d);
    mv = 1'b1;
    dm = d;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (hm) break;
    end
    if (!hm) check("push_m_timeout", 0, 1);
    mv = 1'b0;
  endtask

  task automatic drain(input int n);
    mv   = 1'b0;
    sv   = 1'b0;
    ordy = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    check("rst_valid", ov, 0);
    check("rst_data", dout, 0);
    check("rst_src", osrc, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    q.delete();
    pref = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [8:0] e[$]);
    check({tag, "_len"}, olog.size(), e.size());
    for (int i = 0; i < e.size() && i < olog.size(); i++)
      check(tag, olog[i], e[i]);
    olog.delete();
  endtask

  initial begin
    int im, is;
    logic [8:0] e[$];

    repeat (2) @(posedge clk);
    #1;
    check("init_valid", ov, 0);
    check("init_data", dout, 0);
    check("init_src", osrc, 0);
    arst = 1'b0;

    // Main only, back to back.
    ordy = 1'b1;
    push_m(8'h11);
    push_m(8'h22);
    push_m(8'h33);
    drain(3);
    e = '{9'h011, 9'h022, 9'h033};
    check_log("main_only", e);

    // Async reset with the buffer full.
    ordy = 1'b0;
    push_m(8'h77);
    push_m(8'h78);
    check("full_before_rst", {rm, rs, ov}, 3'b001);
    do_reset();
    cyc();
    olog.delete();

    // Synchronous clear with the buffer full and inputs valid.
    ordy = 1'b0;
    push_m(8'h44);
    push_m(8'h55);
    mv  = 1'b1;
    dm  = 8'h66;
    sv  = 1'b1;
    ds  = 8'h67;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    mv  = 1'b0;
    sv  = 1'b0;
    cyc();
    check("clr_empty", ov, 0);
    check("clr_rdy", {rm, rs}, 2'b11);
    drain(2);
    check("clr_log", olog.size(), 0);

    // Backpressure, then release.
    olog.delete();
    ordy = 1'b0;
    push_m(8'h01);
    push_m(8'h02);
    mv = 1'b1;
    dm = 8'h03;
    cyc();
    cyc();
    check("bp_full", {rm, rs, ov}, 3'b001);
    ordy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (hm) break;
    end
    drain(3);
    e = '{9'h001, 9'h002, 9'h003};
    check_log("bp", e);

`ifdef PIPELINE_MERGE_FAIR_EN
    do_reset();
    ordy = 1'b1;
    im = 0;
    is = 0;
    for (int k = 0; k < 40 && (im < 4 || is < 4); k++) begin
      mv = (im < 4);
      dm = 8'hC0 + 8'(im);
      sv = (is < 4);
      ds = 8'hD0 + 8'(is);
      cyc();
      if (hm) im++;
      if (hs) is++;
    end
    drain(3);
    e = '{9'h0C0, 9'h1D0, 9'h0C1, 9'h1D1,
          9'h0C2, 9'h1D2, 9'h0C3, 9'h1D3};
    check_log("fair", e);
`else
    ordy = 1'b1;
    sv   = 1'b1;
    ds   = 8'h5A;
    push_m(8'hA0);
    push_m(8'hA1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (hs) break;
    end
    drain(3);
    e = '{9'h0A0, 9'h0A1, 9'h15A};
    check_log("prio", e);
`endif

    // Random traffic; inputs hold until their handshake.
    mv = 1'b0;
    sv = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!mv || hm) begin
        mv = 1'($urandom_range(0, 1));
        dm = 8'($urandom);
      end
      if (!sv || hs) begin
        sv = 1'($urandom_range(0, 1));
        ds = 8'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 499) == 0);
      hm   = 1'b0;
      hs   = 1'b0;
      cyc();
    end
    clr = 1'b0;
    drain(4);
    check("rand_drained", q.size(), 0);
    check("rand_final_valid", ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
